// File: rtl/multi_psg_mixer.sv
// multi_psg_mixer: bus-selects one of NCHIP PSG chips and mixes all their channels
// into registered, saturated stereo samples through a serial multiply-free accumulator.
module multi_psg_mixer #(
    parameter int NCHIP   = 2,
    parameter int AW      = 12,
    parameter int OW      = 11,
    parameter int SHIFT   = 5,
    parameter int DEF_SEL = NCHIP - 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ce_i,
    input  logic                  bdir_i,
    input  logic                  bc_i,
    input  logic [7:0]            di_i,
    input  logic [1:0]            mode_i,
    input  logic [NCHIP-1:0]      mute_i,
    input  logic [NCHIP*AW-1:0]   ch_a_i,
    input  logic [NCHIP*AW-1:0]   ch_b_i,
    input  logic [NCHIP*AW-1:0]   ch_c_i,
    input  logic [NCHIP*8-1:0]    chip_do_i,
    output logic [NCHIP-1:0]      chip_bc_o,
    output logic [7:0]            do_o,
    output logic [1:0]            sel_o,
    output logic [OW-1:0]         audio_l_o,
    output logic [OW-1:0]         audio_r_o,
    output logic                  sample_stb_o
);
    localparam int ACC = AW + 4;
    localparam logic [3:0] LAST = 4'(3 * NCHIP - 1);
    localparam logic [ACC-1:0] MAXO = ACC'((1 << OW) - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [NCHIP*AW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0] mode_q, mode_d;
    logic [NCHIP-1:0] mute_q, mute_d;
    logic [3:0] idx_q, idx_d, chip, ch;
    logic [ACC-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d, samp_x, sh_l, sh_r;
    logic [OW-1:0] aud_l_q, aud_l_d, aud_r_q, aud_r_d;
    logic stb_q, stb_d;
    logic [AW-1:0] samp;
    logic [1:0] wl, wr;

    // The select write itself still reaches the chip selected before this edge.
    assign sel_d = (bdir_i && bc_i && di_i[7:2] == 6'h3f && int'(di_i[1:0]) < NCHIP) ? di_i[1:0] : sel_q;
    for (genvar k = 0; k < NCHIP; k++) begin : g_bc
        assign chip_bc_o[k] = bc_i && (sel_q == 2'(k));
    end
    assign do_o = 8'(chip_do_i >> {sel_q, 3'b000});
    assign sel_o = sel_q;
    assign audio_l_o = aud_l_q;
    assign audio_r_o = aud_r_q;
    assign sample_stb_o = stb_q;

    assign chip = idx_q / 4'd3;
    assign ch = idx_q % 4'd3;
    assign samp = 1'(mute_q >> chip) ? '0 :
                  ch == 4'd0 ? AW'(a_q >> (chip * AW)) :
                  ch == 4'd1 ? AW'(b_q >> (chip * AW)) : AW'(c_q >> (chip * AW));
    assign samp_x = ACC'(samp);
    // Weights per panning mode; code 3 falls through to ABC.
    assign wl = mode_q == 2'd2 ? 2'd1 : ch == 4'd0 ? 2'd2 :
                mode_q == 2'd1 ? (ch == 4'd2 ? 2'd1 : 2'd0) : (ch == 4'd1 ? 2'd1 : 2'd0);
    assign wr = mode_q == 2'd2 ? 2'd1 : ch == 4'd0 ? 2'd0 :
                mode_q == 2'd1 ? (ch == 4'd2 ? 2'd1 : 2'd2) : (ch == 4'd1 ? 2'd1 : 2'd2);
    assign sh_l = acc_l_q >> SHIFT;
    assign sh_r = acc_r_q >> SHIFT;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ce_i ? ACCUM : IDLE;
            ACCUM:   state_d = idx_q == LAST ? DONE : ACCUM;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        mode_d = mode_q;
        mute_d = mute_q;
        idx_d = idx_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        aud_l_d = aud_l_q;
        aud_r_d = aud_r_q;
        stb_d = 1'b0;
        if (state_q == IDLE && ce_i) begin
            a_d = ch_a_i;
            b_d = ch_b_i;
            c_d = ch_c_i;
            mode_d = mode_i;
            mute_d = mute_i;
            idx_d = '0;
            acc_l_d = '0;
            acc_r_d = '0;
        end
        if (state_q == ACCUM) begin
            acc_l_d = acc_l_q + (wl == 2'd2 ? samp_x << 1 : wl == 2'd1 ? samp_x : '0);
            acc_r_d = acc_r_q + (wr == 2'd2 ? samp_x << 1 : wr == 2'd1 ? samp_x : '0);
            idx_d = idx_q + 4'd1;
        end
        if (state_q == DONE) begin
            aud_l_d = sh_l > MAXO ? '1 : sh_l[OW-1:0];
            aud_r_d = sh_r > MAXO ? '1 : sh_r[OW-1:0];
            stb_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sel_q <= 2'(DEF_SEL);
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            mode_q <= '0;
            mute_q <= '0;
            idx_q <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            aud_l_q <= '0;
            aud_r_q <= '0;
            stb_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            mode_q <= mode_d;
            mute_q <= mute_d;
            idx_q <= idx_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            aud_l_q <= aud_l_d;
            aud_r_q <= aud_r_d;
            stb_q <= stb_d;
        end
    end
endmodule

// File: tb/tb_multi_psg_mixer.sv
// tb_multi_psg_mixer: scoreboard bench for chip select and the serial stereo mixer,
// run on a SHIFT=5 instance and a SHIFT=0 instance sharing all inputs.
module tb_multi_psg_mixer;
    logic clk = 0, rst = 1, ce = 0, bdir = 0, bc = 0;
    logic [7:0] di = 0;
    logic [1:0] mode = 0, mute = 0;
    logic [23:0] cha = 0, chb = 0, chc = 0;
    logic [15:0] chip_do = 16'hB4A5;
    logic [1:0] chip_bc, chip_bc0, sel, sel0;
    logic [7:0] dout, dout0;
    logic [10:0] al, ar, al0, ar0;
    logic stb, stb0;
    int cyc = 0, checks = 0, fails = 0;
    logic [1:0] esel;

    typedef struct {logic [10:0] l; logic [10:0] r; int due;} exp_t;
    exp_t q5[$], q0[$];
    exp_t e5, e0;

    multi_psg_mixer #(.SHIFT(5)) dut (
        .clk_i(clk), .reset_i(rst), .ce_i(ce), .bdir_i(bdir), .bc_i(bc), .di_i(di),
        .mode_i(mode), .mute_i(mute), .ch_a_i(cha), .ch_b_i(chb), .ch_c_i(chc),
        .chip_do_i(chip_do), .chip_bc_o(chip_bc), .do_o(dout), .sel_o(sel),
        .audio_l_o(al), .audio_r_o(ar), .sample_stb_o(stb));

    multi_psg_mixer #(.SHIFT(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .ce_i(ce), .bdir_i(bdir), .bc_i(bc), .di_i(di),
        .mode_i(mode), .mute_i(mute), .ch_a_i(cha), .ch_b_i(chb), .ch_c_i(chc),
        .chip_do_i(chip_do), .chip_bc_o(chip_bc0), .do_o(dout0), .sel_o(sel0),
        .audio_l_o(al0), .audio_r_o(ar0), .sample_stb_o(stb0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per strobe; a strobe with nothing queued is an error.
    always @(negedge clk) begin
        if (stb) begin
            if (q5.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_stb5: got strobe expected none (cycle %0d)", cyc);
            end else begin
                e5 = q5.pop_front();
                chk("audio_l_s5", 32'(al), 32'(e5.l));
                chk("audio_r_s5", 32'(ar), 32'(e5.r));
                chk("latency_s5", cyc, e5.due);
            end
        end
        if (stb0) begin
            if (q0.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_stb0: got strobe expected none (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("audio_l_s0", 32'(al0), 32'(e0.l));
                chk("audio_r_s0", 32'(ar0), 32'(e0.r));
                chk("latency_s0", cyc, e0.due);
            end
        end
    end

    task automatic issue(input logic [10:0] l5, r5, l0, r0);
        q5.push_back('{l5, r5, cyc + 8});
        q0.push_back('{l0, r0, cyc + 8});
    endtask

    // One mix: inputs are scrambled right after the CE edge to prove the snapshot.
    task automatic vec(input logic [1:0] m, mu, input logic [11:0] a0, b0, c0, a1, b1, c1,
                       input logic [10:0] l5, r5, l0, r0);
        @(negedge clk);
        mode = m;
        mute = mu;
        cha = {a1, a0};
        chb = {b1, b0};
        chc = {c1, c0};
        ce = 1;
        issue(l5, r5, l0, r0);
        @(negedge clk);
        ce = 0;
        cha = 24'($urandom);
        chb = 24'($urandom);
        chc = 24'($urandom);
        mode = 2'($urandom);
        mute = 2'($urandom);
        repeat (8) @(negedge clk);
    endtask

    task automatic sel_wr(input logic b, c, input logic [7:0] d, input logic [1:0] nsel);
        @(negedge clk);
        bdir = b;
        bc = c;
        di = d;
        #1 chk("chip_bc", 32'(chip_bc), c ? 32'(2'b01 << esel) : 0);
        @(negedge clk);
        esel = nsel;
        chk("sel", 32'(sel), 32'(esel));
        chk("do", 32'(dout), esel == 2'd1 ? 32'hB4 : 32'hA5);
        bdir = 0;
        bc = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_sel", 32'(sel), 1);
        chk("reset_audio", {al, ar}, 0);
        chk("reset_stb", 32'(stb), 0);
        rst = 0;
        esel = 2'd1;
        sel_wr(1, 1, 8'hFC, 2'd0);
        sel_wr(1, 1, 8'hFE, 2'd0);
        sel_wr(1, 1, 8'hFD, 2'd1);
        sel_wr(1, 1, 8'h7C, 2'd1);
        sel_wr(0, 1, 8'hFC, 2'd1);
        sel_wr(1, 0, 8'hFC, 2'd1);
        sel_wr(1, 1, 8'hFC, 2'd0);
        vec(2'd0, 2'b00, 12'h800, 12'h800, 12'h800, 0, 0, 0, 11'h0C0, 11'h0C0, 11'h7FF, 11'h7FF);
        vec(2'd0, 2'b00, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
            11'h2FF, 11'h2FF, 11'h7FF, 11'h7FF);
        vec(2'd1, 2'b00, 0, 12'h400, 0, 0, 0, 0, 11'h000, 11'h040, 11'h000, 11'h7FF);
        vec(2'd1, 2'b01, 0, 12'h400, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(2'd2, 2'b00, 0, 0, 0, 12'h100, 12'h200, 12'h300, 11'h030, 11'h030, 11'h600, 11'h600);
        vec(2'd3, 2'b00, 0, 0, 0, 12'h020, 12'h040, 12'h080, 11'h004, 11'h00A, 11'h080, 11'h140);
        vec(2'd0, 2'b10, 12'h200, 0, 0, 12'hFFF, 0, 0, 11'h020, 11'h000, 11'h400, 11'h000);
        vec(2'd1, 2'b00, 12'h010, 12'h020, 12'h030, 12'h001, 12'h002, 12'h003,
            11'h002, 11'h003, 11'h055, 11'h077);
        // CE during ACCUM and during DONE must not queue or restart a mix.
        @(negedge clk);
        mode = 2'd2;
        mute = 0;
        cha = {12'h100, 12'h0};
        chb = {12'h200, 12'h0};
        chc = {12'h300, 12'h0};
        ce = 1;
        issue(11'h030, 11'h030, 11'h600, 11'h600);
        @(negedge clk) ce = 0;
        @(negedge clk);
        @(negedge clk) ce = 1;
        @(negedge clk) ce = 0;
        repeat (2) @(negedge clk);
        @(negedge clk) ce = 1;
        @(negedge clk) ce = 0;
        repeat (10) @(negedge clk);
        // Reset in the middle of a sequence aborts it with no strobe.
        @(negedge clk) ce = 1;
        @(negedge clk) ce = 0;
        @(negedge clk);
        @(negedge clk) ce = 1;
        @(negedge clk);
        ce = 0;
        rst = 1;
        #1;
        chk("abort_audio_s5", {al, ar}, 0);
        chk("abort_audio_s0", {al0, ar0}, 0);
        chk("abort_stb", 32'({stb, stb0}), 0);
        chk("abort_sel", 32'(sel), 1);
        @(negedge clk) rst = 0;
        esel = 2'd1;
        repeat (10) @(negedge clk);
        vec(2'd0, 2'b00, 12'h800, 12'h800, 12'h800, 0, 0, 0, 11'h0C0, 11'h0C0, 11'h7FF, 11'h7FF);
        repeat (3) @(negedge clk);
        chk("queue_drained", q5.size() + q0.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
